// File: rtl/vita_rx_control.sv
// Receive-side timed stream controller: queues stream commands from the settings bus,
// gates the DSP core with run and tags accepted samples with time and burst flags.
module vita_rx_control #(
  parameter int BASE           = 0,
  parameter int WIDTH          = 32,
  parameter int CMD_DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [63:0]               vita_time,
  input  logic [WIDTH-1:0]          sample,
  input  logic                      strobe,
  output logic                      run,
  output logic [WIDTH+67:0]         sample_fifo_o,
  output logic                      sample_fifo_src_rdy_o,
  input  logic                      sample_fifo_dst_rdy_i,
  output logic                      overrun,
  output logic                      late_cmd,
  output logic                      cmd_dropped,
  output logic [CMD_DEPTH_LOG2:0]   cmd_occupancy,
  output logic [31:0]               debug
);

  localparam int DEPTH = 1 << CMD_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RUNNING = 2'd2, ERR = 2'd3} state_t;
  state_t state, state_next;

  // Handshake: a word transfers on a rising edge where src_rdy and dst_rdy are both high;
  // src_rdy never waits on dst_rdy, and a RUNNING strobe without dst_rdy is an overrun.

  logic [31:0]               cmd_reg;
  logic [31:0]               time_hi;
  logic [95:0]               mem [DEPTH];
  logic [CMD_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [95:0]               head;
  logic                      fifo_empty, fifo_full;

  logic                      head_imm, head_chain, head_reload, head_stop;
  logic [27:0]               head_lines;
  logic [63:0]               head_time;

  logic [27:0]               count;
  logic [27:0]               cur_lines;
  logic                      cur_chain, cur_reload;
  logic                      sob_pend;
  logic [63:0]               err_time;
  logic                      err_late, err_overrun;

  logic push_req, push_ok, dropped;
  logic pop, flush, start, accept, chain_pop, reload_same, eob, late_ev, ovr_ev;

  function automatic logic [27:0] lines(input logic [27:0] n);
    return (n == 28'd0) ? 28'd1 : n;
  endfunction

  assign head        = mem[rd_ptr];
  assign head_imm    = head[95];
  assign head_chain  = head[94];
  assign head_reload = head[93];
  assign head_stop   = head[92];
  assign head_lines  = lines(head[91:64]);
  assign head_time   = head[63:0];

  assign fifo_empty = (cmd_occupancy == '0);
  assign fifo_full  = (cmd_occupancy == (CMD_DEPTH_LOG2+1)'(DEPTH));

  assign push_req = set_stb && (set_addr == 8'(BASE + 2));
  assign push_ok  = push_req && !flush && (!fifo_full || pop);
  assign dropped  = push_req && !push_ok && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next            = state;
    pop                   = 1'b0;
    flush                 = 1'b0;
    start                 = 1'b0;
    accept                = 1'b0;
    chain_pop             = 1'b0;
    reload_same           = 1'b0;
    eob                   = 1'b0;
    late_ev               = 1'b0;
    ovr_ev                = 1'b0;
    sample_fifo_src_rdy_o = 1'b0;
    sample_fifo_o         = '0;
    case (state)
      IDLE: if (!fifo_empty) state_next = WAIT;
      WAIT: begin
        if (fifo_empty) begin
          state_next = IDLE;
        end else if (head_stop) begin
          pop        = 1'b1;
          state_next = IDLE;
        end else if (head_imm || vita_time == head_time) begin
          pop        = 1'b1;
          start      = 1'b1;
          state_next = RUNNING;
        end else if (vita_time > head_time) begin
          pop        = 1'b1;
          late_ev    = 1'b1;
          state_next = ERR;
        end
      end
      RUNNING: begin
        if (count == 28'd1) begin
          if (cur_chain && !fifo_empty && !head_stop) chain_pop = 1'b1;
          else if (cur_chain && cur_reload && fifo_empty) reload_same = 1'b1;
          else eob = 1'b1;
        end
        sample_fifo_src_rdy_o = strobe;
        sample_fifo_o         = {sample, vita_time, 2'b00, eob, sob_pend};
        if (strobe && sample_fifo_dst_rdy_i) begin
          accept = 1'b1;
          pop    = chain_pop;
          if (eob) state_next = IDLE;
        end else if (strobe) begin
          ovr_ev     = 1'b1;
          flush      = 1'b1;
          state_next = ERR;
        end
      end
      ERR: begin
        sample_fifo_src_rdy_o = 1'b1;
        sample_fifo_o         = {{WIDTH{1'b0}}, err_time, err_late, err_overrun, 1'b1, 1'b0};
        if (sample_fifo_dst_rdy_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // clear overrides every other event in the same cycle
    if (clear) begin
      state_next = IDLE;
      flush      = 1'b1;
      pop        = 1'b0;
      start      = 1'b0;
      accept     = 1'b0;
      late_ev    = 1'b0;
      ovr_ev     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {cmd_reg, time_hi, set_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_reg       <= '0;
      time_hi       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cmd_occupancy <= '0;
      run           <= 1'b0;
      count         <= '0;
      cur_lines     <= '0;
      cur_chain     <= 1'b0;
      cur_reload    <= 1'b0;
      sob_pend      <= 1'b0;
      err_time      <= '0;
      err_late      <= 1'b0;
      err_overrun   <= 1'b0;
      overrun       <= 1'b0;
      late_cmd      <= 1'b0;
      cmd_dropped   <= 1'b0;
    end else begin
      overrun     <= ovr_ev;
      late_cmd    <= late_ev;
      cmd_dropped <= dropped;
      if (set_stb && set_addr == 8'(BASE))     cmd_reg <= set_data;
      if (set_stb && set_addr == 8'(BASE + 1)) time_hi <= set_data;

      if (flush) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        cmd_occupancy <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        cmd_occupancy <= cmd_occupancy + {{CMD_DEPTH_LOG2{1'b0}}, push_ok}
                                       - {{CMD_DEPTH_LOG2{1'b0}}, pop};
      end

      if (clear) begin
        run         <= 1'b0;
        sob_pend    <= 1'b0;
        count       <= '0;
        err_late    <= 1'b0;
        err_overrun <= 1'b0;
      end else begin
        if (start) begin
          run        <= 1'b1;
          sob_pend   <= 1'b1;
          count      <= head_lines;
          cur_lines  <= head_lines;
          cur_chain  <= head_chain;
          cur_reload <= head_reload;
        end
        if (accept) begin
          sob_pend <= 1'b0;
          if (chain_pop) begin
            count      <= head_lines;
            cur_lines  <= head_lines;
            cur_chain  <= head_chain;
            cur_reload <= head_reload;
          end else if (reload_same) begin
            count <= cur_lines;
          end else if (eob) begin
            run <= 1'b0;
          end else begin
            count <= count - 28'd1;
          end
        end
        if (late_ev) begin
          err_time    <= vita_time;
          err_late    <= 1'b1;
          err_overrun <= 1'b0;
        end
        if (ovr_ev) begin
          run         <= 1'b0;
          err_time    <= vita_time;
          err_late    <= 1'b0;
          err_overrun <= 1'b1;
        end
      end
    end
  end

  assign debug = {state, run, strobe, sample_fifo_src_rdy_o, sample_fifo_dst_rdy_i,
                  cmd_occupancy, {(25-CMD_DEPTH_LOG2){1'b0}}};

endmodule
